// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file with write bypass,
// selectable 1/2-cycle read latency and a hardware clear sequencer.
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NREAD   = 2,
    parameter int RD_LAT  = 2,
    parameter bit ZERO_R0 = 1'b1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);
    localparam logic [AW-1:0] ONE     = AW'(1);
    localparam logic [AW:0]   NREGS_W = (AW + 1)'(NREGS);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;

    logic [XLEN-1:0] mem [NREGS];
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [XLEN-1:0] mem_wd;
    logic            wr_acc;

    // Clear sequencer: walk every entry after reset or a clear request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sequencer state, restarting the clear from entry 0 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

    // A write lands only in IDLE, not in the clear-request cycle, in range,
    // and never to entry 0 when it is hard-wired.
    always_comb begin
        wr_acc = wr_en && (state_q == IDLE) && !clr_req
              && ({1'b0, wr_addr} < NREGS_W)
              && !(ZERO_R0 && (wr_addr == '0));
    end

    // Clear sequencer and write port share the single array write path.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wr_addr;
        mem_wd = wr_data;
        if (state_q == CLEAR) begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = '0;
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
    end

    // Array storage; contents are meaningful only after a full clear.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [AW-1:0]   a;
        logic            a_ok;
        logic [XLEN-1:0] s1_d, s1_q;

        assign a = rd_addr[p*AW +: AW];

        // First read stage: bypass an accepted write, force zeros.
        always_comb begin
            a_ok = ({1'b0, a} < NREGS_W) && !(ZERO_R0 && (a == '0));
            s1_d = '0;
            if (!busy_q && a_ok) begin
                if (wr_acc && (wr_addr == a)) begin
                    s1_d = wr_data;
                end else begin
                    s1_d = mem[a];
                end
            end
        end

        // First read stage register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q <= '0;
            end else begin
                s1_q <= s1_d;
            end
        end

        if (RD_LAT == 1) begin : g_lat1
            assign rd_data[p*XLEN +: XLEN] = s1_q;
        end else begin : g_lat2
            logic [XLEN-1:0] s2_d, s2_q;

            assign s2_d = s1_q;

            // Optional second stage, a plain delay of the first.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_q <= '0;
                end else begin
                    s2_q <= s2_d;
                end
            end

            assign rd_data[p*XLEN +: XLEN] = s2_q;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test of regfile_mp at read latency 2 and 1,
// both instances driven by the same stimulus.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rdd1, rdd2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_req;
    logic        busy1, busy2;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_mp #(.RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy2)
    );

    regfile_mp #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a0,
                          input logic [4:0] a1, input logic [31:0] e0,
                          input logic [31:0] e1);
        set_rd(a0, a1);
        tick();
        chk({tag, "_l1p0"}, rdd1[31:0], e0);
        chk({tag, "_l1p1"}, rdd1[63:32], e1);
        tick();
        chk({tag, "_l2p0"}, rdd2[31:0], e0);
        chk({tag, "_l2p1"}, rdd2[63:32], e1);
    endtask

    function automatic logic [31:0] fv(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;

        tick();
        tick();
        chk("rst_busy2", {31'b0, busy2}, 32'd1);
        chk("rst_busy1", {31'b0, busy1}, 32'd1);
        chk("rst_data2", rdd2[31:0] | rdd2[63:32], 32'd0);
        chk("rst_data1", rdd1[31:0] | rdd1[63:32], 32'd0);

        rst = 1'b0;
        for (int i = 1; i < 32; i++) tick();
        chk("clr31_busy", {31'b0, busy2}, 32'd1);
        tick();
        chk("clr32_busy2", {31'b0, busy2}, 32'd0);
        chk("clr32_busy1", {31'b0, busy1}, 32'd0);

        for (int i = 0; i < 32; i++) begin
            rd_chk("init_zero", 5'(i), 5'(31 - i), 32'd0, 32'd0);
        end

        wr(5'd5, 32'hDEAD_BEEF);
        rd_chk("r5r6", 5'd5, 5'd6, 32'hDEAD_BEEF, 32'd0);

        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'h1234_5678;
        set_rd(5'd7, 5'd7);
        tick();
        wr_en = 1'b0;
        set_rd(5'd0, 5'd0);
        chk("byp_l1p0", rdd1[31:0], 32'h1234_5678);
        chk("byp_l1p1", rdd1[63:32], 32'h1234_5678);
        tick();
        chk("byp_l2p0", rdd2[31:0], 32'h1234_5678);
        chk("byp_l2p1", rdd2[63:32], 32'h1234_5678);

        set_rd(5'd9, 5'd9);
        tick();
        chk("late_l1_old", rdd1[31:0], 32'd0);
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'hA5A5_A5A5;
        tick();
        wr_en = 1'b0;
        chk("late_l2_old", rdd2[31:0], 32'd0);
        chk("late_l1_byp", rdd1[63:32], 32'hA5A5_A5A5);
        tick();
        chk("late_l2_new", rdd2[63:32], 32'hA5A5_A5A5);

        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'hFFFF_FFFF;
        set_rd(5'd0, 5'd0);
        tick();
        wr_en = 1'b0;
        chk("r0_byp_l1", rdd1[31:0] | rdd1[63:32], 32'd0);
        tick();
        chk("r0_byp_l2", rdd2[31:0] | rdd2[63:32], 32'd0);
        chk("r0_next_l1", rdd1[31:0] | rdd1[63:32], 32'd0);
        tick();
        chk("r0_next_l2", rdd2[31:0] | rdd2[63:32], 32'd0);

        for (int i = 1; i < 32; i++) wr(5'(i), fv(i));
        rd_chk("fill", 5'd3, 5'd31, fv(3), fv(31));

        clr_req = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h3333_3333;
        set_rd(5'd31, 5'd3);
        tick();
        clr_req = 1'b0;
        wr_en   = 1'b0;
        chk("clrq_busy", {31'b0, busy1}, 32'd1);
        chk("clrq_l1p0", rdd1[31:0], fv(31));
        chk("clrq_l1p1", rdd1[63:32], fv(3));
        tick();
        chk("clrq_l2p0", rdd2[31:0], fv(31));
        chk("clrq_l2p1", rdd2[63:32], fv(3));
        chk("clr_rd_l1", rdd1[31:0] | rdd1[63:32], 32'd0);
        for (int i = 2; i < 32; i++) tick();
        chk("clr_busy31", {31'b0, busy2}, 32'd1);
        chk("clr_rd_l2", rdd2[31:0] | rdd2[63:32], 32'd0);
        tick();
        chk("clr_busy32", {31'b0, busy2}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            rd_chk("post_clr", 5'(i), 5'(32 - i), 32'd0, 32'd0);
        end

        wr(5'd5, 32'hCAFE_F00D);
        rd_chk("pre_rst", 5'd5, 5'd5, 32'hCAFE_F00D, 32'hCAFE_F00D);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy2 & busy1}, 32'd1);
        chk("arst_l2", rdd2[31:0] | rdd2[63:32], 32'd0);
        chk("arst_l1", rdd1[31:0] | rdd1[63:32], 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) tick();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, busy2}, 32'd1);
        chk("mid_rst_data", rdd2[31:0] | rdd1[31:0], 32'd0);
        rst = 1'b0;
        for (int i = 1; i < 32; i++) tick();
        chk("rst2_busy31", {31'b0, busy2}, 32'd1);
        tick();
        chk("rst2_busy32", {31'b0, busy2}, 32'd0);
        rd_chk("post_rst_r5", 5'd5, 5'd9, 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the IcyRisc core, the next generation of the integer register file. It provides one write port, NREAD independently addressed read ports, a selectable read latency of 1 or 2 cycles, same-cycle write-to-read bypass, and a hardware clear sequencer that zeroes every entry after reset or on request. It sits between decode (read addresses) and writeback (write port).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of entries (2..256); AW = $clog2(NREGS)
- NREAD, 2, number of read ports (1..4)
- RD_LAT, 2, read latency in cycles; legal values 1 or 2
- ZERO_R0, 1, when 1, entry 0 is hard-wired zero

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NREAD*AW  read addresses; port p uses bits [p*AW +: AW]
- rd_data  out  NREAD*XLEN  read data; port p uses bits [p*XLEN +: XLEN]
- wr_en  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- clr_req  in  1  single-cycle request to zero all entries
- busy  out  1  clear sequence in progress; writes ignored, reads return 0

## Operation
- FSM states: CLEAR, IDLE. rst forces CLEAR with clear counter = 0.
- CLEAR: each cycle writes 0 to entry[counter] and increments the counter; after entry NREGS-1 is written, go to IDLE. busy = 1 throughout CLEAR.
- IDLE: clr_req = 1 moves the FSM to CLEAR (counter = 0) on the next edge. In that same cycle, a write is dropped. clr_req is ignored while in CLEAR.
- Write (IDLE only): entry[wr_addr] <= wr_data when wr_en = 1. The write is dropped when wr_addr = 0 and ZERO_R0 = 1, or when wr_addr >= NREGS.
- Read: each port samples rd_addr every cycle; there is no handshake. The returned data is the entry value including any write accepted in the sampling cycle (bypass: if wr_en, wr_addr == rd_addr, and the write is accepted, then wr_data is returned).
- Read forcing to 0: address 0 with ZERO_R0 = 1 (even if a bypassed write targets 0); address >= NREGS; any address sampled while busy = 1.
- Writes accepted after the sampling cycle are not reflected in that read, including writes during the second stage when RD_LAT = 2.
- All read ports are independent. Any number of ports may read the same address, including the write address.

## Timing
- Reset values: rd_data = 0 on all ports; all read pipeline stages = 0; busy = 1; FSM = CLEAR; counter = 0. Array contents are undefined until the clear completes.
- Clear duration: after rst deasserts, busy stays 1 for exactly NREGS rising edges. On the first cycle with busy = 0, a write is accepted. The same applies from the edge at which clr_req is registered.
- Read latency:
  - RD_LAT = 1: address sampled at edge N; rd_data valid after edge N, held until edge N+1.
  - RD_LAT = 2: one additional register stage; data valid after edge N+1.
- Throughput: a new address on every port every cycle; the pipeline is fully pipelined.
- Reads sampled in the last IDLE cycle before CLEAR complete with their normal data. Reads sampled during CLEAR return 0.
- rst asserted mid-operation (mid-clear or mid-read): all outputs and stages take reset values immediately, and the clear restarts from entry 0 on release.
- Bypass priority: an accepted write to the read address in the sampling cycle takes priority over the array value.

## Test plan
- Reset release, NREGS = 32: busy = 1 for 32 edges, then 0. Reading all 32 addresses then returns 0x00000000 on all ports.
- Write 0xDEADBEEF to r5, then read r5 on port 0 and r6 on port 1 next cycle (RD_LAT = 2): after 2 edges, port 0 = 0xDEADBEEF and port 1 = 0.
- Bypass: in the same cycle, set wr_en = 1, wr_addr = 7, wr_data = 0x12345678 and rd_addr = 7 on both ports. Both ports return 0x12345678 at latency RD_LAT. Repeat with RD_LAT = 1.
- r0 with ZERO_R0 = 1: write 0xFFFFFFFF to r0 while reading r0 in the same cycle and the next cycle. Both reads return 0.
- clr_req after filling r1..r31 with nonzero values, plus a write to r3 issued in the clr_req cycle: busy = 1 for 32 cycles, reads during that time return 0, and afterwards r1..r31 all read 0 (including r3).
- rst pulse while busy at counter = 10: rd_data = 0 and busy = 1 immediately. After release, busy stays high for a full NREGS cycles.
